round_judge: RTL
================

// Module: round_judge
// PURPOSE
//  Consumer of the ready-arbiter's OK/NUM handshake; producer of the STATE bus that arbiter watches.
//  On OK rising edge, latches NUM as the round target and opens a timed answer window for 1P and 2P.
//  Judges submissions, drives STATE (1P viewpoint) and per-player lockouts, keeps scores.
//  Returns to IDLE after a result hold; arbiter's ready latches clear on the result STATE codes.
// PARAMETERS
//  TICK_DIV     50_000_000  CLK cycles per 1 s tick
//  TIME_LIMIT   9           answer window, seconds (1..15)
//  RESULT_HOLD  2           seconds a result STATE is held before IDLE (>=1)
// PORTS
//  CLK        in   1  system clock
//  RST        in   1  reset, asynchronous, active-low
//  OK         in   1  round start from arbiter (level; only its rising edge is used)
//  NUM        in   4  round target from arbiter, valid 1..10 while OK high
//  ANS_1P     in   4  1P answer value
//  SUBMIT_1P  in   1  1P submit, one-cycle pulse (pre-debounced)
//  ANS_2P     in   4  2P answer value
//  SUBMIT_2P  in   1  2P submit, one-cycle pulse
//  STATE      out  4  round state code (see BEHAVIOUR)
//  REMAIN     out  4  seconds left in answer window; 0 outside ANSWER
//  TARGET     out  4  latched target; 0 in IDLE
//  LOCK_1P    out  1  1P locked out after wrong answer
//  LOCK_2P    out  1  2P locked out after wrong answer
//  SCORE_1P   out  4  1P wins, saturates at 9
//  SCORE_2P   out  4  2P wins, saturates at 9
// BEHAVIOUR
//  Reset: STATE=IDLE, REMAIN=0, TARGET=0, LOCKs=0, SCOREs=0, tick counter=0; async, mid-round too.
//  STATE codes: IDLE 0000, ANSWER 0010, DRAW 0110, GOOD 1000, OUCH 1001, WIN 1010, LOSE 1011.
//  OK edge: ok_d registered; start = OK & ~ok_d. OK held high must not restart a round.
//  IDLE: start with NUM in 1..10 -> ANSWER next cycle; TARGET<=NUM, REMAIN<=TIME_LIMIT,
//    LOCKs<=0, tick counter<=0. start with NUM 0 or >10 -> ignored, stay IDLE.
//  Submits in IDLE or any result state are ignored; submit from a locked player ignored.
//  ANSWER, per cycle, priority order:
//    1) both unlocked players submit, both ANS==TARGET -> GOOD (no score change).
//    2) 1P correct (2P absent/wrong/locked) -> WIN, SCORE_1P+1 (sat 9).
//    3) 2P correct (1P absent/wrong/locked) -> LOSE, SCORE_2P+1 (sat 9).
//    4) wrong submits set that player's LOCK same cycle; both locked -> OUCH.
//    5) else on tick: REMAIN-1; tick at REMAIN==1 -> DRAW, REMAIN=0.
//  A correct submit and the final tick in the same cycle: submit wins (WIN/LOSE, not DRAW).
//  Result states: REMAIN<=0; hold RESULT_HOLD ticks, tick counter cleared on entry; then IDLE,
//    TARGET<=0, LOCKs<=0. SCOREs persist until reset.
//  All outputs registered; STATE changes 1 cycle after the deciding input cycle.
//  Tick counter free-runs 0..TICK_DIV-1 in ANSWER/results, held at 0 in IDLE.
//  Widths: compare ANS vs TARGET on 4 bits; counter width $clog2(TICK_DIV).
// STRUCTURE
//  Shared package: 4-bit STATE code localparams (IDLE..LOSE), NUM range limits 1/10, score cap 9;
//   the ready arbiter is to use the same package for its clear-state decode.
//  Sub-module tick_gen (TICK_DIV param; CLK, RST, CLR in; TICK out, one-cycle pulse).
//  Top: start-edge detect, FSM, REMAIN/hold counter, lock and score registers.
// TESTING (TICK_DIV=10 in sim)
//  OK 0->1 with NUM=7, hold OK high -> ANSWER, TARGET=7, REMAIN=9; no re-start while high.
//  SUBMIT_1P ANS=7 -> STATE=WIN next cycle, SCORE_1P=1; IDLE after 20 cycles, TARGET=0.
//  SUBMIT_2P ANS=3 then SUBMIT_1P ANS=4 -> LOCK_2P, then OUCH; later 2P submits ignored.
//  No submits -> REMAIN 9..1 per 10 cycles, DRAW at 90 cycles; SUBMIT_1P ANS=7 on final tick -> WIN.
//  Both submit ANS=7 same cycle -> GOOD, scores unchanged; OK rise with NUM=0 or 12 -> stays IDLE.
//  RST low mid-ANSWER -> all outputs zero at once; SCOREs saturate at 9 after 10 wins.

Source files
------------

// File: rtl/round_judge_pkg.sv
// Shared definitions for the round judge and the ready arbiter that watches its STATE bus.
package round_judge_pkg;

  // 4-bit STATE bus codes, 1P viewpoint
  localparam logic [3:0] STATE_IDLE   = 4'b0000;
  localparam logic [3:0] STATE_ANSWER = 4'b0010;
  localparam logic [3:0] STATE_DRAW   = 4'b0110;
  localparam logic [3:0] STATE_GOOD   = 4'b1000;
  localparam logic [3:0] STATE_OUCH   = 4'b1001;
  localparam logic [3:0] STATE_WIN    = 4'b1010;
  localparam logic [3:0] STATE_LOSE   = 4'b1011;

  typedef enum logic [3:0] {
    ST_IDLE   = STATE_IDLE,
    ST_ANSWER = STATE_ANSWER,
    ST_DRAW   = STATE_DRAW,
    ST_GOOD   = STATE_GOOD,
    ST_OUCH   = STATE_OUCH,
    ST_WIN    = STATE_WIN,
    ST_LOSE   = STATE_LOSE
  } state_t;

  // Legal round targets and the score ceiling (single 7-seg digit)
  localparam logic [3:0] NUM_MIN   = 4'd1;
  localparam logic [3:0] NUM_MAX   = 4'd10;
  localparam logic [3:0] SCORE_MAX = 4'd9;

  // True for the codes that end a round; the arbiter clears its ready latches on these
  function automatic logic is_result(input logic [3:0] code);
    return (code == STATE_DRAW) || (code == STATE_GOOD) || (code == STATE_OUCH) ||
           (code == STATE_WIN)  || (code == STATE_LOSE);
  endfunction

  function automatic logic num_valid(input logic [3:0] num);
    return (num >= NUM_MIN) && (num <= NUM_MAX);
  endfunction

  // Score increment that sticks at SCORE_MAX
  function automatic logic [3:0] score_inc(input logic [3:0] score);
    return (score < SCORE_MAX) ? score + 4'd1 : score;
  endfunction

endpackage

// File: rtl/round_judge_tick_gen.sv
// tick_gen: one-cycle TICK pulse every TICK_DIV clocks; CLR restarts the count at zero.
module round_judge_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the last value, forced to zero while cleared
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (CLR || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Count register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign TICK = (cnt_q == CNT_LAST);

endmodule

// File: rtl/round_judge.sv
// Round judge: starts a timed answer round on OK's rising edge, judges both players,
// drives the STATE bus, per-player lockouts and saturating scores.
module round_judge
  import round_judge_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int TIME_LIMIT  = 9,
  parameter int RESULT_HOLD = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       OK,
  input  logic [3:0] NUM,
  input  logic [3:0] ANS_1P,
  input  logic       SUBMIT_1P,
  input  logic [3:0] ANS_2P,
  input  logic       SUBMIT_2P,
  output logic [3:0] STATE,
  output logic [3:0] REMAIN,
  output logic [3:0] TARGET,
  output logic       LOCK_1P,
  output logic       LOCK_2P,
  output logic [3:0] SCORE_1P,
  output logic [3:0] SCORE_2P
);

  localparam int HW = $clog2(RESULT_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RESULT_HOLD - 1);
  localparam logic [3:0]    REMAIN_INIT = 4'(TIME_LIMIT);

  state_t        state_q, state_d;
  logic          ok_q, ok_d;
  logic [3:0]    remain_q, remain_d;
  logic [3:0]    target_q, target_d;
  logic          lock_1p_q, lock_1p_d;
  logic          lock_2p_q, lock_2p_d;
  logic [3:0]    score_1p_q, score_1p_d;
  logic [3:0]    score_2p_q, score_2p_d;
  logic [HW-1:0] hold_q, hold_d;

  logic start;
  logic tick;
  logic tick_clr;
  logic valid_1p, valid_2p;
  logic hit_1p, hit_2p;

  // Tick counter is held in IDLE and restarted on every state change, so each
  // answer window and result hold begins with a full second.
  round_judge_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (tick_clr),
    .TICK (tick)
  );

  // Round FSM with its timer, lock and score datapath
  always_comb begin
    ok_d       = OK;
    state_d    = state_q;
    remain_d   = remain_q;
    target_d   = target_q;
    lock_1p_d  = lock_1p_q;
    lock_2p_d  = lock_2p_q;
    score_1p_d = score_1p_q;
    score_2p_d = score_2p_q;
    hold_d     = hold_q;

    start    = OK & ~ok_q;
    valid_1p = SUBMIT_1P & ~lock_1p_q;
    valid_2p = SUBMIT_2P & ~lock_2p_q;
    hit_1p   = valid_1p & (ANS_1P == target_q);
    hit_2p   = valid_2p & (ANS_2P == target_q);

    case (state_q)
      ST_IDLE: begin
        if (start && num_valid(NUM)) begin
          state_d   = ST_ANSWER;
          target_d  = NUM;
          remain_d  = REMAIN_INIT;
          lock_1p_d = 1'b0;
          lock_2p_d = 1'b0;
        end
      end

      ST_ANSWER: begin
        if (hit_1p && hit_2p) begin
          state_d = ST_GOOD;
        end else if (hit_1p) begin
          state_d    = ST_WIN;
          score_1p_d = score_inc(score_1p_q);
        end else if (hit_2p) begin
          state_d    = ST_LOSE;
          score_2p_d = score_inc(score_2p_q);
        end else begin
          // Any surviving valid submit here is wrong
          lock_1p_d = lock_1p_q | valid_1p;
          lock_2p_d = lock_2p_q | valid_2p;
          if (lock_1p_d && lock_2p_d) begin
            state_d = ST_OUCH;
          end else if (tick) begin
            if (remain_q <= 4'd1) begin
              state_d = ST_DRAW;
            end else begin
              remain_d = remain_q - 4'd1;
            end
          end
        end
        if (state_d != ST_ANSWER) begin
          remain_d = 4'd0;
          hold_d   = '0;
        end
      end

      default: begin
        // Result states: show the outcome for RESULT_HOLD seconds, then go idle
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d   = ST_IDLE;
            target_d  = 4'd0;
            lock_1p_d = 1'b0;
            lock_2p_d = 1'b0;
            hold_d    = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
    endcase

    tick_clr = (state_q == ST_IDLE) || (state_d != state_q);
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      ok_q       <= 1'b0;
      remain_q   <= 4'd0;
      target_q   <= 4'd0;
      lock_1p_q  <= 1'b0;
      lock_2p_q  <= 1'b0;
      score_1p_q <= 4'd0;
      score_2p_q <= 4'd0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      ok_q       <= ok_d;
      remain_q   <= remain_d;
      target_q   <= target_d;
      lock_1p_q  <= lock_1p_d;
      lock_2p_q  <= lock_2p_d;
      score_1p_q <= score_1p_d;
      score_2p_q <= score_2p_d;
      hold_q     <= hold_d;
    end
  end

  assign STATE    = state_q;
  assign REMAIN   = remain_q;
  assign TARGET   = target_q;
  assign LOCK_1P  = lock_1p_q;
  assign LOCK_2P  = lock_2p_q;
  assign SCORE_1P = score_1p_q;
  assign SCORE_2P = score_2p_q;

endmodule
